// File: rtl/mem_port_arbiter_if.sv
// Request/ack bundle for the fetch and data ports plus the shared memory strobe bus.
// The arbiter takes the slave view; pipeline stages and memory together form the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serializes fetch and data-port accesses onto the single-ported memory, with a
// fixed read latency and a bounded number of data grants while a fetch waits.
//
// state | meaning
// IDLE  | sample requests, grant one, latch its address/we/wdata
// ISSUE | mem_en strobe for the latched access, load latency counter
// WAIT  | count down to the cycle mem_rdata is valid, capture on reads
// ACK   | one-cycle ack to the owner, requests ignored
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [STV_W-1:0]  starve_cnt;
    logic              own_if, own_we;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              mem_en_q, mem_we_q, if_ack_q, dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

    logic grant_if, sample, capture;
    logic mem_en_d, mem_we_d, if_ack_d, dm_ack_d;

    // A waiting fetch overrides data priority only once the data port has used its quota.
    assign grant_if = bus.if_req && (!bus.dm_req || starve_cnt == STV_TOP);
    assign sample   = (state == IDLE) && (bus.if_req || bus.dm_req);
    assign capture  = (state == WAIT) && (wait_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            own_if     <= 1'b0;
            own_we     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mem_en_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            if_ack_q   <= 1'b0;
            dm_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state    <= next_state;
            mem_en_q <= mem_en_d;
            mem_we_q <= mem_we_d;
            if_ack_q <= if_ack_d;
            dm_ack_q <= dm_ack_d;
            if (sample) begin
                own_if  <= grant_if;
                own_we  <= !grant_if && bus.dm_we;
                addr_q  <= grant_if ? bus.if_addr : bus.dm_addr;
                wdata_q <= grant_if ? '0 : bus.dm_wdata;
                if (grant_if)
                    starve_cnt <= '0;
                else if (bus.if_req && starve_cnt != STV_TOP)
                    starve_cnt <= starve_cnt + STV_W'(1);
            end
            if (state == ISSUE)
                wait_cnt <= CNT_LOAD;
            else if (state == WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - CNT_W'(1);
            if (capture && !own_we) begin
                if (own_if)
                    if_rdata_q <= bus.mem_rdata;
                else
                    dm_rdata_q <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.if_req || bus.dm_req) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (wait_cnt == '0) next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered, so decode them from the state being entered.
    always_comb begin
        mem_en_d = (next_state == ISSUE);
        mem_we_d = mem_en_d && !grant_if && bus.dm_we;
        if_ack_d = (next_state == ACK) && own_if;
        dm_ack_d = (next_state == ACK) && !own_if;
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Random and directed traffic on both ports against a transaction-timing model,
// plus latency checks on extra instances built with other memory latencies.
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // memory behaviour: contents plus the pending read return
    logic [31:0] mem [logic [31:0]];
    int          mem_due = -1;
    logic [31:0] mem_dq  = '0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    // reference model: one transaction at a time, timed from its sample cycle
    int          next_sample = 0;
    int          exp_issue   = -1;
    int          exp_ack     = -1;
    int          starve      = 0;
    bit          t_if, t_we;
    logic [31:0] t_addr, t_wdata, t_rdata;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_dm_rdata = '0;

    bit auto_if = 0, auto_dm = 0, hold_if = 0, hold_dm = 0;

    task automatic new_if();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'($urandom_range(0, 15)) << 2;
    endtask

    task automatic new_dm();
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'($urandom_range(0, 1));
        bus.dm_addr  = 32'($urandom_range(0, 15)) << 2;
        bus.dm_wdata = $urandom;
    endtask

    task automatic model_reset();
        exp_issue   = -1;
        exp_ack     = -1;
        next_sample = 0;
        starve      = 0;
        m_if_rdata  = '0;
        m_dm_rdata  = '0;
        mem_due     = -1;
    endtask

    task automatic model_sample(input int c);
        if (rst) return;
        if (c >= next_sample && (bus.if_req || bus.dm_req)) begin
            t_if = bus.if_req && (!bus.dm_req || starve == SMAX);
            if (t_if) begin
                starve  = 0;
                t_we    = 1'b0;
                t_addr  = bus.if_addr;
                t_wdata = '0;
            end else begin
                if (bus.if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
                t_we    = bus.dm_we;
                t_addr  = bus.dm_addr;
                t_wdata = bus.dm_wdata;
            end
            t_rdata     = mem_val(t_addr);
            exp_issue   = c + 1;
            exp_ack     = c + 2 + LAT;
            next_sample = c + 3 + LAT;
        end
    endtask

    task automatic cycle_checks(input int n);
        check_eq("mem_en", bus.mem_en, n == exp_issue);
        if (n == exp_issue) begin
            check_eq("mem_we", bus.mem_we, t_we);
            check_eq("mem_addr", bus.mem_addr, t_addr);
            if (t_we) check_eq("mem_wdata", bus.mem_wdata, t_wdata);
        end else begin
            check_eq("mem_we_idle", bus.mem_we, 1'b0);
        end
        check_eq("if_ack", bus.if_ack, (n == exp_ack) && t_if);
        check_eq("dm_ack", bus.dm_ack, (n == exp_ack) && !t_if);
        if (n == exp_ack && !t_we) begin
            if (t_if) m_if_rdata = t_rdata;
            else      m_dm_rdata = t_rdata;
        end
        check_eq("if_rdata", bus.if_rdata, m_if_rdata);
        check_eq("dm_rdata", bus.dm_rdata, m_dm_rdata);
        // memory reacts to the strobe it sees
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
            else begin
                mem_due = n + LAT;
                mem_dq  = mem_val(bus.mem_addr);
            end
        end
        // requesters drop or re-issue on their ack
        if (bus.if_ack) begin
            if (hold_if || (auto_if && $urandom_range(0, 1) == 1)) new_if();
            else bus.if_req = 1'b0;
        end
        if (bus.dm_ack) begin
            if (hold_dm || (auto_dm && $urandom_range(0, 1) == 1)) new_dm();
            else bus.dm_req = 1'b0;
        end
    endtask

    task automatic step(input bit pulse_rst = 1'b0);
        @(posedge clk);
        model_sample(cyc);
        cyc++;
        #1;
        bus.mem_rdata = (cyc == mem_due) ? mem_dq : $urandom;
        if (auto_if && !bus.if_req && $urandom_range(0, 2) == 0) new_if();
        if (auto_dm && !bus.dm_req && $urandom_range(0, 2) == 0) new_dm();
        if (pulse_rst) begin
            rst = 1'b1;
            model_reset();
            #1;
            check_eq("rst_mem_en", bus.mem_en, 1'b0);
            check_eq("rst_mem_we", bus.mem_we, 1'b0);
            check_eq("rst_mem_addr", bus.mem_addr, '0);
            check_eq("rst_mem_wdata", bus.mem_wdata, '0);
            check_eq("rst_acks", {bus.if_ack, bus.dm_ack}, 2'b00);
            check_eq("rst_rdata", {bus.if_rdata, bus.dm_rdata}, '0);
        end
        @(negedge clk);
        cycle_checks(cyc);
    endtask

    task automatic wait_ack(input bit dm, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (dm ? bus.dm_ack : bus.if_ack) begin
                at = cyc;
                break;
            end
        end
        check_eq("ack_timeout", at != -1, 1'b1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 100; i++) begin
            if (!bus.if_req && !bus.dm_req && cyc >= next_sample) break;
            step();
        end
        check_eq("drain_timeout", i < 100, 1'b1);
    endtask

    // latency sweep on instances with other MEM_LAT values
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int L = (g == 0) ? 1 : 5;
        logic rst_s;
        bit   done = 1'b0;
        mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sbus ();
        mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L), .STARVE_MAX(SMAX)) sdut (
            .clk(clk),
            .rst(rst_s),
            .bus(sbus)
        );
        initial begin
            int n;
            rst_s          = 1'b1;
            sbus.if_req    = 1'b0;
            sbus.if_addr   = '0;
            sbus.dm_req    = 1'b0;
            sbus.dm_we     = 1'b0;
            sbus.dm_addr   = '0;
            sbus.dm_wdata  = '0;
            sbus.mem_rdata = 32'h1234_0000 + L;
            repeat (2) @(negedge clk);
            rst_s = 1'b0;
            @(negedge clk);
            sbus.if_req  = 1'b1;
            sbus.if_addr = 32'h80;
            n = 0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                n++;
                if (sbus.if_ack) break;
            end
            check_eq("sweep_latency", n, L + 2);
            check_eq("sweep_rdata", sbus.if_rdata, 32'h1234_0000 + L);
            sbus.if_req = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int c, at, n_dm;
        logic [31:0] old;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        model_reset();
        step();
        step();
        rst = 1'b0;

        // single fetch
        mem[32'h40] = 32'h8C01_0004;
        c = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h40;
        wait_ack(1'b0, at);
        check_eq("fetch_ack_cycle", at, c + LAT + 2);
        check_eq("fetch_rdata", bus.if_rdata, 32'h8C01_0004);
        drain();

        // data write leaves dm_rdata alone
        old = bus.dm_rdata;
        c = cyc;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h100;
        bus.dm_wdata = 32'hDEAD_BEEF;
        wait_ack(1'b1, at);
        check_eq("write_ack_cycle", at, c + 4);
        check_eq("write_keeps_rdata", bus.dm_rdata, old);
        drain();

        // simultaneous: data first, fetch served next
        c = cyc;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h44;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h100;
        wait_ack(1'b1, at);
        check_eq("simul_dm_ack", at, c + 4);
        check_eq("simul_dm_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        wait_ack(1'b0, at);
        check_eq("simul_if_ack", at, c + 9);
        drain();

        // starvation guard: both held, data port re-issues after every ack
        hold_if = 1'b1;
        hold_dm = 1'b1;
        new_if();
        new_dm();
        n_dm = 0;
        at = -1;
        for (int i = 0; i < 80; i++) begin
            step();
            if (bus.dm_ack) n_dm++;
            if (bus.if_ack) begin
                at = cyc;
                break;
            end
        end
        check_eq("starve_if_granted", at != -1, 1'b1);
        check_eq("starve_dm_acks", n_dm, SMAX);
        hold_if = 1'b0;
        hold_dm = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        drain();

        // guard cleared: data wins again on a fresh collision
        c = cyc;
        new_if();
        new_dm();
        wait_ack(1'b1, at);
        check_eq("starve_cleared", at, c + 4);
        drain();

        // reset in the first WAIT cycle of a data read
        c = cyc;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h100;
        step();
        step(1'b1);
        step();
        rst = 1'b0;
        wait_ack(1'b1, at);
        check_eq("rst_reissue_ack", at, c + 3 + LAT + 2);
        check_eq("rst_reissue_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        drain();

        // random traffic
        auto_if = 1'b1;
        auto_dm = 1'b1;
        repeat (1500) step();
        auto_if = 1'b0;
        auto_dm = 1'b0;
        drain();

        check_eq("sweep_done", g_sweep[0].done && g_sweep[1].done, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
